// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencing FSM: keypad entry, code check, unlock/alarm timing,
// failure lockout and in-place code reprogramming while open.
module combo_lock_ctrl #(
    parameter int CODE_LEN    = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int UNLOCK_CYC  = 500,
    parameter int LOCKOUT_CYC = 1000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                             Clock,
    input  logic                             Resetn,
    input  logic                             key_valid,
    input  logic [DIGIT_W-1:0]               key_digit,
    input  logic                             enter,
    input  logic                             clear,
    input  logic                             prog_req,
    output logic                             unlocked,
    output logic                             alarm,
    output logic                             err,
    output logic                             prog_mode,
    output logic                             prog_done,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]   attempts
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int ATT_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_W  = $clog2(((UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC) + 1);

    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(CODE_LEN);
    localparam logic [ATT_W-1:0] TRIES_LIMIT = ATT_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] UNLOCK_T    = TMR_W'(UNLOCK_CYC);
    localparam logic [TMR_W-1:0] LOCKOUT_T   = TMR_W'(LOCKOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(1);

    typedef enum logic [2:0] {
        IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT, PROG
    } state_e;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ATT_W-1:0]   attempts_q, attempts_d;
    logic               prog_done_q, prog_done_d;

    logic               key_ok;
    logic               flush;
    logic               entry_full;
    logic [ATT_W-1:0]   att_inc;

    // NOTE: the entry buffer is reset like any other register so a reset mid-entry
    // or mid-programming can never leave stale digits behind.
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            code_q      <= DEFAULT_CODE;
            buf_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            timer_q     <= '0;
            attempts_q  <= '0;
            prog_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            timer_q     <= timer_d;
            attempts_q  <= attempts_d;
            prog_done_q <= prog_done_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        buf_d       = buf_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        timer_d     = timer_q;
        attempts_d  = attempts_q;
        prog_done_d = 1'b0;
        flush       = 1'b0;
        key_ok      = key_valid & ~enter & ~clear;
        entry_full  = (count_q == FULL_CNT) & ~ovf_q;
        att_inc     = attempts_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (key_ok) begin
                    buf_d[CODE_W-1 -: DIGIT_W] = key_digit;
                    count_d = CNT_W'(1);
                    state_d = ENTRY;
                end
            end

            ENTRY, PROG: begin
                if (clear) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (enter) begin
                    if (state_q == ENTRY) begin
                        state_d = CHECK;
                    end else begin
                        // Short or overflowed entries leave the stored code untouched.
                        if (entry_full) begin
                            code_d      = buf_q;
                            prog_done_d = 1'b1;
                        end
                        flush   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (key_valid) begin
                    if (count_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < CODE_LEN; i++) begin
                            if (count_q == CNT_W'(i)) begin
                                buf_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = key_digit;
                            end
                        end
                        count_d = count_q + 1'b1;
                    end
                end
            end

            CHECK: begin
                flush = 1'b1;
                if (entry_full && (buf_q == code_q)) begin
                    attempts_d = '0;
                    timer_d    = UNLOCK_T;
                    state_d    = OPEN;
                end else begin
                    attempts_d = att_inc;
                    if (att_inc == TRIES_LIMIT) begin
                        timer_d = LOCKOUT_T;
                        state_d = LOCKOUT;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end

            FAIL: state_d = IDLE;

            OPEN: begin
                timer_d = timer_q - 1'b1;
                if (enter || (timer_q == TMR_LAST)) begin
                    state_d = IDLE;
                end else if (prog_req) begin
                    state_d = PROG;
                end
            end

            LOCKOUT: begin
                timer_d = timer_q - 1'b1;
                if (timer_q == TMR_LAST) begin
                    attempts_d = '0;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (flush) begin
            buf_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    assign unlocked    = (state_q == OPEN);
    assign alarm       = (state_q == LOCKOUT);
    assign err         = (state_q == FAIL);
    assign prog_mode   = (state_q == PROG);
    assign prog_done   = prog_done_q;
    assign digit_count = count_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed self-checking bench for combo_lock_ctrl: unlock timing, failure counting,
// lockout, entry edge cases, reprogramming, asynchronous reset and input priority.
module tb_combo_lock_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = '0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       prog_req = 1'b0;
    logic       unlocked, alarm, err, prog_mode, prog_done;
    logic [2:0] digit_count;
    logic [1:0] attempts;

    int total = 0;
    int bad   = 0;

    combo_lock_ctrl dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .enter       (enter),
        .clear       (clear),
        .prog_req    (prog_req),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .err         (err),
        .prog_mode   (prog_mode),
        .prog_done   (prog_done),
        .digit_count (digit_count),
        .attempts    (attempts)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_prog();
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
    endtask

    // Four keys plus enter, then one more edge: the CHECK result is visible on return.
    task automatic try_code(input logic [3:0] a, b, c, d);
        press(a); press(b); press(c); press(d);
        pulse_enter();
        tick();
    endtask

    initial begin
        #2;
        check("rst_unlocked", unlocked, 0);
        check("rst_alarm", alarm, 0);
        check("rst_err", err, 0);
        check("rst_prog_mode", prog_mode, 0);
        check("rst_prog_done", prog_done, 0);
        check("rst_count", digit_count, 0);
        check("rst_attempts", attempts, 0);
        tick();
        Resetn = 1'b1;
        tick();

        // Correct code: unlocked two edges after enter, held 500 cycles.
        press(1); press(2); press(3); press(4);
        check("count_full", digit_count, 4);
        pulse_enter();
        check("unlock_not_yet", unlocked, 0);
        tick();
        check("unlock_high", unlocked, 1);
        check("unlock_attempts", attempts, 0);
        repeat (499) tick();
        check("unlock_last_cycle", unlocked, 1);
        tick();
        check("unlock_expired", unlocked, 0);

        // Three wrong entries: err pulses, then lockout.
        try_code(1, 2, 3, 5);
        check("fail1_err", err, 1);
        check("fail1_attempts", attempts, 1);
        tick();
        check("fail1_err_pulse", err, 0);
        try_code(1, 2, 3, 5);
        check("fail2_err", err, 1);
        check("fail2_attempts", attempts, 2);
        tick();
        try_code(1, 2, 3, 5);
        check("lockout_alarm", alarm, 1);
        check("lockout_err", err, 0);
        check("lockout_attempts", attempts, 3);
        press(1);
        check("lockout_key_ignored", digit_count, 0);
        pulse_enter();
        repeat (997) tick();
        check("lockout_last_cycle", alarm, 1);
        tick();
        check("lockout_expired", alarm, 0);
        check("lockout_attempts_cleared", attempts, 0);

        // Overflowed and short entries both fail.
        press(1); press(2); press(3); press(4); press(9);
        check("ovf_count_saturates", digit_count, 4);
        pulse_enter();
        tick();
        check("ovf_err", err, 1);
        check("ovf_attempts", attempts, 1);
        tick();
        press(1); press(2); press(3);
        pulse_enter();
        tick();
        check("short_err", err, 1);
        check("short_attempts", attempts, 2);
        tick();

        // Clear abandons the entry but keeps the failure count.
        press(1); press(2);
        pulse_clear();
        check("clear_count", digit_count, 0);
        check("clear_keeps_attempts", attempts, 2);
        try_code(1, 2, 3, 4);
        check("after_clear_unlock", unlocked, 1);
        check("after_clear_attempts", attempts, 0);

        // Reprogram to 9876 while open.
        pulse_prog();
        check("prog_mode", prog_mode, 1);
        check("prog_unlocked_low", unlocked, 0);
        press(9); press(8); press(7); press(6);
        pulse_enter();
        check("prog_done_pulse", prog_done, 1);
        check("prog_mode_exit", prog_mode, 0);
        tick();
        check("prog_done_cleared", prog_done, 0);
        try_code(1, 2, 3, 4);
        check("old_code_fails", err, 1);
        tick();
        try_code(9, 8, 7, 6);
        check("new_code_unlocks", unlocked, 1);
        pulse_enter();
        check("manual_relock", unlocked, 0);

        // Reset in the middle of a lockout.
        tick();
        try_code(0, 0, 0, 0); tick();
        try_code(0, 0, 0, 0); tick();
        try_code(0, 0, 0, 0);
        check("lockout2_alarm", alarm, 1);
        repeat (5) tick();
        Resetn = 1'b0;
        #1;
        check("rst_lockout_alarm", alarm, 0);
        check("rst_lockout_attempts", attempts, 0);
        tick();
        Resetn = 1'b1;
        tick();

        // Reset restored the default code; then reset in the middle of programming.
        try_code(1, 2, 3, 4);
        check("default_code_restored", unlocked, 1);
        pulse_prog();
        press(5); press(5);
        check("prog_partial_count", digit_count, 2);
        Resetn = 1'b0;
        #1;
        check("rst_prog_mode", prog_mode, 0);
        check("rst_prog_count", digit_count, 0);
        check("rst_prog_unlocked", unlocked, 0);
        tick();
        Resetn = 1'b1;
        tick();
        try_code(1, 2, 3, 4);
        check("prog_discarded", unlocked, 1);
        pulse_enter();

        // clear + enter + key in the same cycle: only clear takes effect.
        press(1); press(2);
        clear = 1'b1; enter = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
        tick();
        clear = 1'b0; enter = 1'b0; key_valid = 1'b0;
        check("prio_count", digit_count, 0);
        tick();
        check("prio_no_check_err", err, 0);
        check("prio_no_unlock", unlocked, 0);
        check("prio_attempts", attempts, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
